pll_rst_seq: RTL and testbench



---
 rtl/pll_rst_seq_pkg.sv | 12 +
 rtl/pll_rst_seq_if.sv | 18 +
 rtl/pll_rst_seq_sync_2ff.sv | 19 +
 rtl/pll_rst_seq.sv | 104 ++++++++++
 tb/tb_pll_rst_seq.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/pll_rst_seq_pkg.sv
// Shared state codes and constants for the PLL reset sequencer.
package pll_rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'b00,
    ST_HOLD      = 2'b01,
    ST_RUN       = 2'b10
  } rst_state_e;

  localparam logic [7:0] LOCK_CNT_MAX = 8'hFF;

endpackage

// File: rtl/pll_rst_seq_if.sv
// Board-side signals of the reset sequencer: PLL lock and button in, core reset and debug out.
interface pll_rst_seq_if;
  logic       pll_locked;
  logic       btn_rst_n;
  logic       cpu_rst_n;
  logic [1:0] rst_state;
  logic [7:0] lock_loss_cnt;

  modport master (
    output pll_locked, btn_rst_n,
    input  cpu_rst_n, rst_state, lock_loss_cnt
  );

  modport slave (
    input  pll_locked, btn_rst_n,
    output cpu_rst_n, rst_state, lock_loss_cnt
  );
endinterface

// File: rtl/pll_rst_seq_sync_2ff.sv
// 1-bit two-flop synchronizer; both flops reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/pll_rst_seq.sv
// Reset sequencer: releases cpu_rst_n after PLL lock and button release are stable for HOLD_CYCLES.
// Optional button debounce is enabled by defining RST_DEBOUNCE_EN.
module pll_rst_seq
  import pll_rst_seq_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES     = 16,
  parameter int unsigned CNT_W           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 1024
) (
  input logic          clk,
  input logic          rst_n,
  pll_rst_seq_if.slave bus
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > (2**CNT_W) - 1 || DEBOUNCE_CYCLES < 1) begin : g_param_chk
    $error("pll_rst_seq: illegal parameter value");
  end

  logic lock_s;
  logic btn_s;
  logic btn_ok;

  sync_2ff u_sync_lock (.clk(clk), .rst_n(rst_n), .d(bus.pll_locked), .q(lock_s));
  sync_2ff u_sync_btn  (.clk(clk), .rst_n(rst_n), .d(bus.btn_rst_n),  .q(btn_s));

`ifdef RST_DEBOUNCE_EN
  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [DB_W-1:0] db_cnt;

  // btn_ok flips on the edge after btn_s has disagreed with it for DEBOUNCE_CYCLES edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_ok <= 1'b0;
      db_cnt <= '0;
    end else if (btn_s == btn_ok) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES)) begin
      btn_ok <= btn_s;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end
`else
  assign btn_ok = btn_s;
`endif

  rst_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       loss, loss_nxt;
  logic             cpu_rst_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_WAIT_LOCK;
      cnt       <= '0;
      loss      <= '0;
      cpu_rst_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      loss      <= loss_nxt;
      cpu_rst_q <= (state_nxt == ST_RUN);
    end
  end

  always_comb begin
    state_nxt = ST_WAIT_LOCK;
    cnt_nxt   = '0;
    loss_nxt  = loss;
    case (state)
      ST_WAIT_LOCK: begin
        if (lock_s && btn_ok) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        // abort outranks completion, so a glitch on the last hold cycle still restarts
        if (lock_s && btn_ok) begin
          if (cnt == HOLD_LAST) begin
            state_nxt = ST_RUN;
          end else begin
            state_nxt = ST_HOLD;
            cnt_nxt   = cnt + 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          if (loss != LOCK_CNT_MAX) loss_nxt = loss + 8'd1;
        end else if (btn_ok) begin
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_WAIT_LOCK;
    endcase
  end

  assign bus.cpu_rst_n     = cpu_rst_q;
  assign bus.rst_state     = state;
  assign bus.lock_loss_cnt = loss;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Self-checking bench for pll_rst_seq: directed table, corner sequences and randomized run against a model.
module tb_pll_rst_seq;

  localparam int unsigned HOLD = 16;
`ifdef RST_DEBOUNCE_EN
  localparam int unsigned DEB   = 8;
  localparam bit          DB_ON = 1'b1;
`else
  localparam int unsigned DEB   = 1024;
  localparam bit          DB_ON = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  pll_rst_seq_if bus_if ();

  pll_rst_seq #(
    .HOLD_CYCLES    (HOLD),
    .CNT_W          (8),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if.slave)
  );

  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Reference model: a stable-cycle streak decides the state, synchronizers are a 2-deep history.
  bit          m_l1, m_l2, m_b1, m_b2, m_bok;
  int unsigned m_dc, m_streak, m_loss;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_l1 = 0; m_l2 = 0; m_b1 = 0; m_b2 = 0; m_bok = 0;
      m_dc = 0; m_streak = 0; m_loss = 0;
    end else begin : mdl
      bit ok, g;
      ok = DB_ON ? m_bok : m_b2;
      g  = m_l2 && ok;
      if (m_streak > HOLD && !m_l2 && m_loss < 255) m_loss++;
      if (!g) m_streak = 0;
      else if (m_streak <= HOLD) m_streak++;
      if (DB_ON) begin
        if (m_b2 == m_bok) m_dc = 0;
        else if (m_dc == DEB) begin m_bok = m_b2; m_dc = 0; end
        else m_dc++;
      end
      m_l2 = m_l1; m_l1 = bus_if.pll_locked;
      m_b2 = m_b1; m_b1 = bus_if.btn_rst_n;
    end
  end

  function automatic int unsigned model_state();
    if (m_streak == 0) return 0;
    if (m_streak <= HOLD) return 1;
    return 2;
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk_out(input string name, input int unsigned cpu, input int unsigned st,
                         input int unsigned loss);
    chk({name, ".cpu_rst_n"}, bus_if.cpu_rst_n, cpu);
    chk({name, ".rst_state"}, bus_if.rst_state, st);
    chk({name, ".lock_loss_cnt"}, bus_if.lock_loss_cnt, loss);
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          lock;
    bit          btn;
    int unsigned cycles;
    bit          exp_cpu;
    int unsigned exp_st;
    int unsigned exp_loss;
  } vec_t;

  vec_t vecs[$];

  initial begin
    bus_if.pll_locked = 1'b0;
    bus_if.btn_rst_n  = 1'b1;

    step(5);
    chk_out("reset", 0, 0, 0);
    rst_n = 1'b1;

    // lock rises, holds, runs; a 4-cycle lock drop re-enters reset and is counted
    vecs.push_back('{0, 1, 14, 0, 0, 0});
    vecs.push_back('{1, 1,  2, 0, 0, 0});
    vecs.push_back('{1, 1,  1, 0, 1, 0});
    vecs.push_back('{1, 1, 15, 0, 1, 0});
    vecs.push_back('{1, 1,  1, 1, 2, 0});
    vecs.push_back('{1, 1,  5, 1, 2, 0});
    vecs.push_back('{0, 1,  2, 1, 2, 0});
    vecs.push_back('{0, 1,  1, 0, 0, 1});
    vecs.push_back('{0, 1,  1, 0, 0, 1});
    vecs.push_back('{1, 1, 18, 0, 1, 1});
    vecs.push_back('{1, 1,  1, 1, 2, 1});
    foreach (vecs[i]) begin
      bus_if.pll_locked = vecs[i].lock;
      bus_if.btn_rst_n  = vecs[i].btn;
      step(vecs[i].cycles);
      chk_out($sformatf("vec%0d", i), vecs[i].exp_cpu, vecs[i].exp_st, vecs[i].exp_loss);
    end

    // lock loss and button press together: counted once
    bus_if.pll_locked = 1'b0;
    bus_if.btn_rst_n  = 1'b0;
    step(3);
    chk_out("both_drop", 0, 0, 2);
    bus_if.pll_locked = 1'b1;
    bus_if.btn_rst_n  = 1'b1;
    step(10);
    chk_out("hold_cnt7", 0, 1, 2);

    // one-cycle lock glitch at cnt=7 restarts the full hold period
    bus_if.pll_locked = 1'b0;
    step(1);
    bus_if.pll_locked = 1'b1;
    step(2);
    chk_out("glitch_wait", 0, 0, 2);
    step(1);
    chk_out("glitch_rehold", 0, 1, 2);
    step(15);
    chk_out("glitch_still_hold", 0, 1, 2);
    step(1);
    chk_out("glitch_run", 1, 2, 2);

    // repeated lock losses saturate the counter
    for (int i = 0; i < 300; i++) begin
      bus_if.pll_locked = 1'b0;
      step(3);
      bus_if.pll_locked = 1'b1;
      step(19);
      if (i == 251) chk("sat_254", bus_if.lock_loss_cnt, 254);
      if (i == 252) chk("sat_255", bus_if.lock_loss_cnt, 255);
    end
    chk_out("saturated", 1, 2, 255);

`ifdef RST_DEBOUNCE_EN
    bus_if.btn_rst_n = 1'b0;
    step(5);
    bus_if.btn_rst_n = 1'b1;
    step(20);
    chk_out("bounce_ignored", 1, 2, 255);
    bus_if.btn_rst_n = 1'b0;
    step(11);
    chk_out("press_not_yet", 1, 2, 255);
    step(1);
    chk_out("press_reset", 0, 0, 255);
    step(8);
    bus_if.btn_rst_n = 1'b1;
    step(40);
    chk_out("release_run", 1, 2, 255);
`else
    bus_if.btn_rst_n = 1'b0;
    step(2);
    chk_out("press_not_yet", 1, 2, 255);
    step(1);
    chk_out("press_reset", 0, 0, 255);
    bus_if.btn_rst_n = 1'b1;
    step(19);
    chk_out("release_run", 1, 2, 255);
`endif

    // asynchronous reset between clock edges, from RUN and from HOLD
    #2 rst_n = 1'b0;
    #1 chk_out("async_rst_run", 0, 0, 0);
    step(2);
    rst_n = 1'b1;
    step(DB_ON ? 20 : 8);
    chk("pre_async_hold", bus_if.rst_state, 1);
    #2 rst_n = 1'b0;
    #1 chk_out("async_rst_hold", 0, 0, 0);
    step(2);
    rst_n = 1'b1;

    // randomized lock/button activity against the model
    for (int i = 0; i < 4000; i++) begin
      if (bus_if.pll_locked) begin
        if ($urandom_range(0, 49) == 0) bus_if.pll_locked = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        bus_if.pll_locked = 1'b1;
      end
      if (bus_if.btn_rst_n) begin
        if ($urandom_range(0, 79) == 0) bus_if.btn_rst_n = 1'b0;
      end else if ($urandom_range(0, DB_ON ? 9 : 3) == 0) begin
        bus_if.btn_rst_n = 1'b1;
      end
      step(1);
      chk("rnd.cpu_rst_n", bus_if.cpu_rst_n, (m_streak > HOLD) ? 1 : 0);
      chk("rnd.rst_state", bus_if.rst_state, model_state());
      chk("rnd.lock_loss_cnt", bus_if.lock_loss_cnt, m_loss);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
